// File: rtl/time_display_scan_pkg.sv
// rtl/time_display_scan_pkg.sv - shared constants, glyph table and field mapping for the time display scanner
package time_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [5:0] SEL_OFF  = 6'h3F;

  // Active-low a..g glyphs indexed by nibble value; 10..15 render as a dash.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Bit positions of the set-mode lines inside control.
  localparam logic [1:0] FIELD_HOUR = 2'd2;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd0;

  // Digits that carry the colon dot.
  localparam logic [2:0] DIGIT_HOUR_UNITS = 3'd1;
  localparam logic [2:0] DIGIT_MIN_UNITS  = 3'd3;

  // Map a digit position to the control bit that governs its field.
  function automatic logic [1:0] field_of_digit(input logic [2:0] digit);
    if (digit < 3'd2)      return FIELD_HOUR;
    else if (digit < 3'd4) return FIELD_MIN;
    else                   return FIELD_SEC;
  endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// rtl/time_display_scan_if.sv - time/control inputs and segment/select outputs of the display scanner
interface time_display_scan_if;
  logic        en;
  logic [23:0] time_in;
  logic [2:0]  control;
  logic [7:0]  seg;
  logic [5:0]  sel;

  modport master (output en, output time_in, output control, input seg, input sel);
  modport slave  (input en, input time_in, input control, output seg, output sel);
endinterface

// File: rtl/time_display_scan_bcd_to_seg7.sv
// rtl/time_display_scan_bcd_to_seg7.sv - BCD nibble to active-low 7-segment glyph, dash for codes above 9
module bcd_to_seg7
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Straight table lookup; invalid BCD entries hold the dash glyph.
  assign seg_n = SEG7_TABLE[bcd];

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - 6-digit multiplexed 7-segment scanner with frame snapshot and set-mode blink; optional colon via TIME_DISPLAY_SCAN_COLON_EN
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int SCAN_HZ  = 6000,
  parameter int BLINK_HZ = 2
) (
  input logic             clk,
  input logic             rst_n,
  time_display_scan_if.slave disp
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SCAN_W    = $clog2(SCAN_DIV);
  localparam int BLINK_W   = $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [2:0]         LAST_DIGIT = 3'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [2:0]         digit_idx;
  logic [23:0]        snapshot;
  logic               scan_tick;
  logic [3:0]         nibble;
  logic [6:0]         glyph_n;
  logic               dp_n;
  logic               blanked;

  assign scan_tick = (scan_cnt == SCAN_LAST);

  // Digit-step divider, digit index and once-per-frame snapshot of the time word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      snapshot  <= '0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        if (digit_idx == LAST_DIGIT) begin
          digit_idx <= '0;
          snapshot  <= disp.time_in;
        end else begin
          digit_idx <= digit_idx + 3'd1;
        end
      end
    end
  end

  // Blink divider runs independently of en so the blink cadence never stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Pick the snapshot nibble for the digit being scanned, leftmost digit first.
  always_comb begin
    nibble = snapshot[23:20];
    case (digit_idx)
      3'd0:    nibble = snapshot[23:20];
      3'd1:    nibble = snapshot[19:16];
      3'd2:    nibble = snapshot[15:12];
      3'd3:    nibble = snapshot[11:8];
      3'd4:    nibble = snapshot[7:4];
      3'd5:    nibble = snapshot[3:0];
      default: nibble = snapshot[23:20];
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (nibble),
    .seg_n (glyph_n)
  );

  assign blanked = blink_phase & ~disp.control[field_of_digit(digit_idx)];

`ifdef TIME_DISPLAY_SCAN_COLON_EN
  assign dp_n = ~(~blink_phase &
                  ((digit_idx == DIGIT_HOUR_UNITS) || (digit_idx == DIGIT_MIN_UNITS)));
`else
  assign dp_n = 1'b1;
`endif

  // Registered digit drive; a blanked digit also suppresses its dot.
  always_ff @(posedge clk) begin
    if (!rst_n || !disp.en) begin
      disp.seg <= SEG_OFF;
      disp.sel <= SEL_OFF;
    end else begin
      disp.sel <= ~(6'b000001 << digit_idx);
      disp.seg <= blanked ? SEG_OFF : {dp_n, glyph_n};
    end
  end

endmodule
